// File: rtl/aes_pipe_scheduler.sv
// Slot scheduler for the 3-stage recirculating AES decryption pipeline.
// Chooses recirculate / retire / inject at the data-select point each cycle.
module aes_pipe_scheduler #(
    parameter int DEPTH  = 3,
    parameter int ROUNDS = 10,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       key_ready,
    input  logic                       flush,
    input  logic                       in_empty,
    output logic                       in_pop,
    output logic                       read_fifo,
    input  logic                       data_done,
    input  logic                       out_full,
    output logic                       out_push,
    output logic                       pipe_stall,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] in_flight,
    output logic [CNT_W-1:0]           blk_count,
    output logic                       sync_err
);

    localparam int HW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(ROUNDS + 1);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [HW-1:0] HEAD_MAX = HW'(DEPTH - 1);
    localparam logic [LW-1:0] LAP_MAX  = LW'(ROUNDS);
    localparam logic [LW-1:0] LAP_LAST = LW'(ROUNDS - 1);

    logic [DEPTH-1:0] valid;
    logic [LW-1:0]    lap [DEPTH];
    logic [HW-1:0]    head;

    logic          hv;
    logic          done_h;
    logic          inject;
    logic          lap_end;
    logic [LW-1:0] lap_h;
    logic [FW-1:0] cnt;

    assign hv     = valid[head];
    assign lap_h  = lap[head];
    assign done_h = hv & data_done;

    // lap holds laps completed before the current return, so the block
    // arriving now finishes its final lap when the stored count is ROUNDS-1
    assign lap_end = (lap_h == LAP_LAST);

    assign pipe_stall = n_rst & done_h & out_full & ~flush;
    assign out_push   = n_rst & done_h & ~out_full & ~flush;
    assign inject     = n_rst & (~hv | out_push) & ~in_empty & key_ready
                      & ~flush & ~pipe_stall;
    assign read_fifo  = inject;
    assign in_pop     = inject;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + FW'(valid[i]);
        end
    end

    assign busy      = |valid;
    assign in_flight = cnt;

    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            valid     <= '0;
            head      <= '0;
            blk_count <= '0;
            sync_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                lap[i] <= '0;
            end
        end else if (!pipe_stall) begin
            head <= (head == HEAD_MAX) ? '0 : head + 1'b1;
            if (inject) begin
                valid[head] <= 1'b1;
                lap[head]   <= '0;
            end else if (hv && !data_done) begin
                if (lap_h != LAP_MAX) begin
                    lap[head] <= lap_h + 1'b1;
                end
            end else begin
                valid[head] <= 1'b0;
                lap[head]   <= '0;
            end
            if (out_push) begin
                blk_count <= blk_count + 1'b1;
            end
            if (hv && (data_done != lap_end)) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Bench for aes_pipe_scheduler: datapath and FIFOs modelled as timed blocks
// (inject time in unstalled cycles; each block is due 30 unstalled cycles later).
module tb_aes_pipe_scheduler;

    logic        clk = 1'b0;
    logic        n_rst, key_ready, flush, in_empty, data_done, out_full;
    logic        in_pop, read_fifo, out_push, pipe_stall, busy, sync_err;
    logic [1:0]  in_flight;
    logic [15:0] blk_count;

    aes_pipe_scheduler dut (
        .clk(clk), .n_rst(n_rst), .key_ready(key_ready), .flush(flush),
        .in_empty(in_empty), .in_pop(in_pop), .read_fifo(read_fifo),
        .data_done(data_done), .out_full(out_full), .out_push(out_push),
        .pipe_stall(pipe_stall), .busy(busy), .in_flight(in_flight),
        .blk_count(blk_count), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int q[$];
    int ac, blk, di;
    bit serr, hv_m, due_m, force_dd, garb_en;
    bit e_st, e_push, e_pop;
    logic [23:0] exp_v;
    wire  [23:0] got_v = {in_pop, read_fifo, out_push, pipe_stall, busy,
                          in_flight, blk_count, sync_err};

    task automatic model_clear();
        q.delete();
        ac = 0; blk = 0; serr = 0;
    endtask

    task automatic eval_cycle();
        hv_m = 0; due_m = 0; di = -1;
        foreach (q[i]) begin
            if ((ac - q[i]) % 3 == 0) begin
                hv_m = 1; di = i;
                due_m = (ac - q[i] == 30);
            end
        end
        data_done = due_m | force_dd
                  | (garb_en && !hv_m && $urandom_range(0, 1) == 1);
        @(negedge clk);
        if (!n_rst) begin
            e_st = 0; e_push = 0; e_pop = 0;
        end else begin
            e_st   = hv_m & data_done & out_full & !flush;
            e_push = hv_m & data_done & !out_full & !flush;
            e_pop  = (!hv_m | e_push) & !in_empty & key_ready & !flush & !e_st;
        end
        exp_v = {e_pop, e_pop, e_push, e_st, q.size() > 0,
                 2'(q.size()), 16'(blk), serr};
    endtask

    task automatic advance();
        @(posedge clk);
        if (!n_rst || flush) begin
            model_clear();
        end else if (!e_st) begin
            if (hv_m && (data_done != due_m)) serr = 1;
            if (e_push) begin
                q.delete(di);
                blk = (blk + 1) % 65536;
            end
            if (e_pop) q.push_back(ac);
            ac++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        n_rst = 1; key_ready = 1; flush = 0; in_empty = 1; out_full = 0;
        force_dd = 0; garb_en = 0;
    endtask

    task automatic test_reset();
        n_rst = 0; in_empty = 0; key_ready = 1; force_dd = 1;
        for (int c = 0; c < 2; c++) begin
            eval_cycle();
            checks++;
            if (got_v !== 24'h0) begin
                errors++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, got_v, 24'h0);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_single_block();
        int push_t = -1;
        for (int c = 0; c < 40; c++) begin
            in_empty = (c != 0);
            eval_cycle();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL single c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (out_push && push_t < 0) push_t = c;
            advance();
        end
        checks++;
        if (push_t != 30) begin
            errors++;
            $display("FAIL single_latency got=%0d exp=30", push_t);
        end
        checks++;
        if (blk_count !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end got=%0d/%b exp=1/0", blk_count, busy);
        end
    endtask

    task automatic test_full_load();
        int pend = 5;
        int pops[$];
        int pushes[$];
        int peak = 0;
        int exp_pops[5] = '{0, 1, 2, 30, 31};
        int exp_push[5] = '{30, 31, 32, 60, 61};
        for (int c = 0; c < 70; c++) begin
            in_empty = (pend == 0);
            eval_cycle();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL full c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (in_pop) begin pops.push_back(c); pend--; end
            if (out_push) pushes.push_back(c);
            if (int'(in_flight) > peak) peak = int'(in_flight);
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= pops.size() || i >= pushes.size() ||
                pops[i] != exp_pops[i] || pushes[i] != exp_push[i]) begin
                errors++;
                $display("FAIL full_timing i=%0d got_pop=%0d got_push=%0d exp=%0d/%0d",
                         i, (i < pops.size()) ? pops[i] : -1,
                         (i < pushes.size()) ? pushes[i] : -1,
                         exp_pops[i], exp_push[i]);
            end
        end
        checks++;
        if (peak != 3) begin
            errors++;
            $display("FAIL full_peak got=%0d exp=3", peak);
        end
    endtask

    task automatic test_backpressure();
        int stalls = 0, bad_pops = 0, push_t = -1;
        for (int c = 0; c < 45; c++) begin
            in_empty = !(c == 0 || (c >= 30 && c <= 33));
            out_full = (c >= 30 && c <= 33);
            eval_cycle();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL backp c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (pipe_stall) stalls++;
            if (pipe_stall && (in_pop || out_push)) bad_pops++;
            if (out_push && push_t < 0) push_t = c;
            advance();
        end
        out_full = 0;
        checks++;
        if (stalls != 4 || bad_pops != 0 || push_t != 34) begin
            errors++;
            $display("FAIL backp_sum got=%0d/%0d/%0d exp=4/0/34",
                     stalls, bad_pops, push_t);
        end
    endtask

    task automatic test_flush();
        int pushes = 0;
        for (int c = 0; c < 58; c++) begin
            in_empty = !(c <= 2 || c == 17);
            flush = (c == 17);
            eval_cycle();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL flush c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c == 17) begin
                checks++;
                if (in_pop || out_push || pipe_stall) begin
                    errors++;
                    $display("FAIL flush_cycle got=%b%b%b exp=000",
                             in_pop, out_push, pipe_stall);
                end
            end
            if (c == 18) begin
                checks++;
                if (in_flight !== 2'd0 || blk_count !== 16'd0) begin
                    errors++;
                    $display("FAIL flush_clear got=%0d/%0d exp=0/0",
                             in_flight, blk_count);
                end
            end
            if (c > 17 && out_push) pushes++;
            advance();
        end
        flush = 0;
        checks++;
        if (pushes != 0) begin
            errors++;
            $display("FAIL flush_nopush got=%0d exp=0", pushes);
        end
    endtask

    task automatic test_desync();
        garb_en = 1;
        for (int c = 0; c < 29; c++) begin
            in_empty = (c != 0);
            force_dd = (c == 12);
            flush = (c == 26);
            eval_cycle();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL desync c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c >= 13 && c <= 26) begin
                checks++;
                if (sync_err !== 1'b1) begin
                    errors++;
                    $display("FAIL desync_sticky c=%0d got=%b exp=1", c, sync_err);
                end
            end
            if (c == 27) begin
                checks++;
                if (sync_err !== 1'b0) begin
                    errors++;
                    $display("FAIL desync_clear got=%b exp=0", sync_err);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_key_ready();
        for (int c = 0; c < 21; c++) begin
            key_ready = (c >= 5);
            in_empty = !(c <= 7);
            n_rst = !(c == 15 || c == 16);
            eval_cycle();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL keyrdy c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c <= 5) begin
                checks++;
                if (in_pop !== (c == 5)) begin
                    errors++;
                    $display("FAIL keyrdy_pop c=%0d got=%b exp=%b", c, in_pop, c == 5);
                end
            end
            if (c == 17) begin
                checks++;
                if (in_flight !== 2'd0 || busy !== 1'b0 || blk_count !== 16'd0) begin
                    errors++;
                    $display("FAIL keyrdy_reset got=%0d/%b/%0d exp=0/0/0",
                             in_flight, busy, blk_count);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        garb_en = 1;
        for (int c = 0; c < 500; c++) begin
            in_empty  = ($urandom_range(0, 1) == 0);
            key_ready = ($urandom_range(0, 6) != 0);
            out_full  = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 149) == 0);
            eval_cycle();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        n_rst = 0;
        data_done = 0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_single_block();
        test_full_load();
        test_backpressure();
        test_flush();
        test_desync();
        test_key_ready();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
